// File: rtl/scmp_microcode_pak.sv
// Shared microcode-level types: ALU opcodes, the decimal-add sequencer states, and a BCD adjust helper.
// Pure declarations; no timing or flow control.
package scmp_microcode_pak;

  typedef enum logic [2:0] {
    ALU_OP_ADD    = 3'd0,
    ALU_OP_AND    = 3'd1,
    ALU_OP_OR     = 3'd2,
    ALU_OP_XOR    = 3'd3,
    ALU_OP_PASS_B = 3'd4
  } ALU_OP_t;

  typedef enum logic [2:0] {
    DAD_IDLE   = 3'd0,
    DAD_LO_ADD = 3'd1,
    DAD_LO_ADJ = 3'd2,
    DAD_HI_ADD = 3'd3,
    DAD_HI_ADJ = 3'd4,
    DAD_DONE   = 3'd5
  } DAD_STATE_t;

  // A 5-bit nibble sum above 9 needs +6 to wrap into the next decade.
  function automatic logic [7:0] bcd_adj(input logic [4:0] sum);
    return (sum > 5'd9) ? 8'h06 : 8'h00;
  endfunction

endpackage

// File: rtl/scmp_alu.sv
// Combinational 8-bit ALU shared by the core and the decimal-add sequencer.
// Zero latency; no flow control, result follows the inputs.
module scmp_alu
  import scmp_microcode_pak::*;
(
  input  ALU_OP_t    i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cy,
  output logic [7:0] o_res,
  output logic       o_cy,
  output logic       o_ov
);

  logic [8:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {8'h00, i_cy};

  always_comb begin
    o_res = 8'h00;
    o_cy  = 1'b0;
    o_ov  = 1'b0;
    case (i_op)
      ALU_OP_ADD: begin
        o_res = w_sum[7:0];
        o_cy  = w_sum[8];
        o_ov  = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      end
      ALU_OP_AND:    o_res = i_a & i_b;
      ALU_OP_OR:     o_res = i_a | i_b;
      ALU_OP_XOR:    o_res = i_a ^ i_b;
      ALU_OP_PASS_B: o_res = i_b;
      default:       o_res = 8'h00;
    endcase
  end

endmodule

// File: rtl/scmp_dad_seq.sv
// Decimal add (DAD/DAE) sequencer: four ADD steps on the shared ALU, fixed 5-cycle latency start->done.
// No backpressure: start is taken only in IDLE and ignored otherwise; result/cy_o hold until overwritten.
module scmp_dad_seq
  import scmp_microcode_pak::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cy_i,
  output logic       busy,
  output logic       alu_own,
  output ALU_OP_t    alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cy,
  input  logic [7:0] alu_res,
  output logic [7:0] result,
  output logic       cy_o,
  output logic       done
);

  DAD_STATE_t r_state;
  DAD_STATE_t w_next;
  logic [7:0] r_ra;
  logic [7:0] r_rb;
  logic       r_rc;
  logic [4:0] r_lo;
  logic [3:0] r_lo_d;
  logic       r_lc;
  logic [4:0] r_hi;
  logic [7:0] r_result;
  logic       r_cy;
  logic       r_busy;
  logic       w_unused_res;

  // Only the nibble sum plus its carry is ever consumed.
  assign w_unused_res = &{1'b0, alu_res[7:5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DAD_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DAD_IDLE:   if (start) w_next = DAD_LO_ADD;
      DAD_LO_ADD: w_next = DAD_LO_ADJ;
      DAD_LO_ADJ: w_next = DAD_HI_ADD;
      DAD_HI_ADD: w_next = DAD_HI_ADJ;
      DAD_HI_ADJ: w_next = DAD_DONE;
      DAD_DONE:   w_next = DAD_IDLE;
      default:    w_next = DAD_IDLE;
    endcase
  end

  // ALU drive is decoded from registered state only, so start never reaches the ALU combinationally.
  always_comb begin
    alu_own = 1'b0;
    alu_op  = ALU_OP_ADD;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cy  = 1'b0;
    case (r_state)
      DAD_LO_ADD: begin
        alu_own = 1'b1;
        alu_a   = {4'h0, r_ra[3:0]};
        alu_b   = {4'h0, r_rb[3:0]};
        alu_cy  = r_rc;
      end
      DAD_LO_ADJ: begin
        alu_own = 1'b1;
        alu_a   = {3'b000, r_lo};
        alu_b   = bcd_adj(r_lo);
      end
      DAD_HI_ADD: begin
        alu_own = 1'b1;
        alu_a   = {4'h0, r_ra[7:4]};
        alu_b   = {4'h0, r_rb[7:4]};
        alu_cy  = r_lc;
      end
      DAD_HI_ADJ: begin
        alu_own = 1'b1;
        alu_a   = {3'b000, r_hi};
        alu_b   = bcd_adj(r_hi);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra     <= 8'h00;
      r_rb     <= 8'h00;
      r_rc     <= 1'b0;
      r_lo     <= 5'h00;
      r_lo_d   <= 4'h0;
      r_lc     <= 1'b0;
      r_hi     <= 5'h00;
      r_result <= 8'h00;
      r_cy     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= (w_next != DAD_IDLE);
      case (r_state)
        DAD_IDLE: if (start) begin
          r_ra <= a;
          r_rb <= b;
          r_rc <= cy_i;
        end
        DAD_LO_ADD: r_lo <= alu_res[4:0];
        DAD_LO_ADJ: begin
          r_lo_d <= alu_res[3:0];
          r_lc   <= (r_lo > 5'd9);
        end
        DAD_HI_ADD: r_hi <= alu_res[4:0];
        DAD_HI_ADJ: begin
          r_result <= {alu_res[3:0], r_lo_d};
          r_cy     <= (r_hi > 5'd9);
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = (r_state == DAD_DONE);
  assign result = r_result;
  assign cy_o   = r_cy;

endmodule

// File: tb/tb_scmp_dad_seq.sv
// Bench for scmp_dad_seq driving a real scmp_alu through the ownership mux; decimal reference model.
module tb_scmp_dad_seq;
  import scmp_microcode_pak::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cy_i;
  logic       busy, alu_own, alu_cy, cy_o, done;
  ALU_OP_t    alu_op;
  logic [7:0] alu_a, alu_b, alu_res, result;

  ALU_OP_t    core_op;
  logic [7:0] core_a, core_b;
  ALU_OP_t    mux_op;
  logic [7:0] mux_a, mux_b;
  logic       mux_cy, alu_cy_out, alu_ov_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scmp_dad_seq dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cy_i(cy_i),
    .busy(busy), .alu_own(alu_own), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cy(alu_cy), .alu_res(alu_res),
    .result(result), .cy_o(cy_o), .done(done)
  );

  assign mux_op = alu_own ? alu_op : core_op;
  assign mux_a  = alu_own ? alu_a  : core_a;
  assign mux_b  = alu_own ? alu_b  : core_b;
  assign mux_cy = alu_own ? alu_cy : 1'b1;

  scmp_alu u_alu (
    .i_op(mux_op), .i_a(mux_a), .i_b(mux_b), .i_cy(mux_cy),
    .o_res(alu_res), .o_cy(alu_cy_out), .o_ov(alu_ov_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: treat operands as two-digit decimal numbers.
  function automatic logic [8:0] bcd_ref(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s, r;
    s = int'(x[7:4]) * 10 + int'(x[3:0]) + int'(y[7:4]) * 10 + int'(y[3:0]) + int'(c);
    r = s % 100;
    return {(s >= 100), 4'(r / 10), 4'(r % 10)};
  endfunction

  function automatic logic [7:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_own"},  alu_own, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_op"},   32'(alu_op), 32'(ALU_OP_ADD));
    chk({tag, "_alua"}, alu_a, 0);
    chk({tag, "_alub"}, alu_b, 0);
  endtask

  // Called in an IDLE cycle; start is sampled at the next edge. pulse[n] re-asserts start in cycle n.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic [5:0] pulse);
    logic [8:0] exp;
    int lo_s, hi_s, lc;
    exp  = bcd_ref(ia, ib, ic);
    lo_s = int'(ia[3:0]) + int'(ib[3:0]) + int'(ic);
    lc   = (lo_s > 9) ? 1 : 0;
    hi_s = int'(ia[7:4]) + int'(ib[7:4]) + lc;
    start = 1'b1; a = ia; b = ib; cy_i = ic;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cy_i = 1'($urandom);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      chk("busy", busy, 1);
      chk("own", alu_own, (cyc <= 4) ? 1 : 0);
      chk("done", done, (cyc == 5) ? 1 : 0);
      chk("op", 32'(alu_op), 32'(ALU_OP_ADD));
      case (cyc)
        1: begin
          chk("lo_add_a", alu_a, ia[3:0]);
          chk("lo_add_b", alu_b, ib[3:0]);
          chk("lo_add_c", alu_cy, ic);
        end
        2: begin
          chk("lo_adj_a", alu_a, lo_s);
          chk("lo_adj_b", alu_b, (lo_s > 9) ? 6 : 0);
          chk("lo_adj_c", alu_cy, 0);
        end
        3: begin
          chk("hi_add_a", alu_a, ia[7:4]);
          chk("hi_add_b", alu_b, ib[7:4]);
          chk("hi_add_c", alu_cy, lc);
        end
        4: begin
          chk("hi_adj_a", alu_a, hi_s);
          chk("hi_adj_b", alu_b, (hi_s > 9) ? 6 : 0);
          chk("hi_adj_c", alu_cy, 0);
        end
        default: begin
          chk("result", result, exp[7:0]);
          chk("cy_o", cy_o, exp[8]);
          chk("done_alua", alu_a, 0);
        end
      endcase
      if (pulse[cyc]) begin
        start = 1'b1; a = 8'($urandom); b = 8'($urandom); cy_i = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    idle_checks("post");
    chk("result_hold", result, exp[7:0]);
    chk("cy_hold", cy_o, exp[8]);
  endtask

  always @(negedge clk) begin
    core_op = ALU_OP_t'($urandom_range(1, 4));
    core_a  = 8'($urandom);
    core_b  = 8'($urandom);
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cy_i = 1'b0;
    #12;
    idle_checks("rst");
    chk("rst_result", result, 0);
    chk("rst_cy", cy_o, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'h45, 8'h38, 1'b0, 6'b0);
    run_op(8'h99, 8'h01, 1'b0, 6'b0);
    run_op(8'h99, 8'h99, 1'b1, 6'b0);
    run_op(8'h00, 8'h00, 1'b0, 6'b0);
    run_op(8'h12, 8'h34, 1'b0, 6'b100100);
    run_op(8'h27, 8'h58, 1'b1, 6'b0);

    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        idle_checks("gap");
      end
      run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)), 6'b0);
    end

    run_op(8'h45, 8'h38, 1'b0, 6'b0);
    start = 1'b1; a = 8'h55; b = 8'h55; cy_i = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_own", alu_own, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_own", alu_own, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cy", cy_o, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_op(8'h19, 8'h28, 1'b0, 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scmp_dad_seq.md
# scmp_dad_seq

Multi-cycle sequencer that implements the SC/MP decimal add (DAD/DAE) by driving the shared binary ALU through four ADD steps: low-nibble add, low-nibble adjust, high-nibble add, high-nibble adjust. It sits beside the ALU in the CPU datapath. While busy, it takes ownership of the ALU operand and opcode muxes. When it finishes, it returns the packed BCD result and carry to the microcode engine.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a decimal add; sampled only in IDLE.
- a  in  8  accumulator operand, packed BCD.
- b  in  8  memory operand, packed BCD.
- cy_i  in  1  incoming carry/link.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- alu_own  out  1  high in the four ALU step states; the core mux selects the sequencer's ALU inputs.
- alu_op  out  ALU_OP_t  opcode to the ALU; ALU_OP_ADD whenever alu_own is high.
- alu_a  out  8  ALU A operand.
- alu_b  out  8  ALU B operand.
- alu_cy  out  1  ALU carry-in.
- alu_res  in  8  ALU result, combinational from the alu_* outputs.
- result  out  8  packed BCD sum; held until the next accepted start.
- cy_o  out  1  decimal carry-out; held like result.
- done  out  1  one-cycle pulse; result and cy_o are valid in this cycle.

## Operation

- States: IDLE, LO_ADD, LO_ADJ, HI_ADD, HI_ADJ, DONE.
- IDLE & start → LO_ADD. Latch a, b and cy_i into internal registers ra, rb, rc.
- LO_ADD: alu_a={4'h0,ra[3:0]}, alu_b={4'h0,rb[3:0]}, alu_cy=rc. Register lo=alu_res[4:0].
- LO_ADJ: alu_a={3'b0,lo}, alu_b=(lo>9)?8'h06:8'h00, alu_cy=0.
  - Register lo_d=alu_res[3:0].
  - Register lc=(lo>9).
- HI_ADD: alu_a={4'h0,ra[7:4]}, alu_b={4'h0,rb[7:4]}, alu_cy=lc. Register hi=alu_res[4:0].
- HI_ADJ: alu_a={3'b0,hi}, alu_b=(hi>9)?8'h06:8'h00, alu_cy=0.
  - Register result={alu_res[3:0],lo_d}.
  - Register cy_o=(hi>9).
- DONE: done=1, then go to IDLE.
- Adjust steps always execute, adding 0 when no correction is needed, so latency is fixed.
- ALU carry-out and overflow are ignored. OV is not produced; the core leaves OV untouched for DAD.
- Non-BCD nibbles are not flagged. They are computed mechanically by the rules above.
- Outside the step states:
  - alu_own=0.
  - alu_op=ALU_OP_ADD.
  - alu_a=alu_b=8'h00, alu_cy=0.
- start outside IDLE is ignored, including in the DONE cycle. No queuing.
- Reset values:
  - State goes to IDLE.
  - busy=0, alu_own=0, done=0.
  - result=8'h00, cy_o=0.
  - Internal registers are cleared.
- Reset mid-operation aborts immediately. No done pulse is issued and result returns to 8'h00.

## Timing

- start is sampled at edge 0. Steps occupy cycles 1–4 (LO_ADD…HI_ADJ) and done is high in cycle 5.
- The next start can be accepted at edge 6 at the earliest.
- The ALU path is combinational: alu_* outputs → alu_res → sequencer register within one cycle.
- alu_* outputs are decoded from registered state only, with no combinational path from start.
- busy is a registered decode of state ≠ IDLE. alu_own is a decode of state ∈ {LO_ADD, LO_ADJ, HI_ADD, HI_ADJ}.

## Structure

- Add a DAD_STATE_t enum to scmp_microcode_pak. ALU_OP_t already lives there.
- The module is a single FSM plus datapath registers with no sub-module. The ALU is instantiated by the parent and muxed via alu_own.
- The test bench instantiates scmp_alu with the mux so that real ALU arithmetic is exercised.

## Test plan

- a=8'h45, b=8'h38, cy_i=0 → done in cycle 5, result=8'h83, cy_o=0.
- a=8'h99, b=8'h01, cy_i=0 → result=8'h00, cy_o=1. a=8'h99, b=8'h99, cy_i=1 → result=8'h99, cy_o=1.
- a=8'h00, b=8'h00, cy_i=0 → result=8'h00, cy_o=0, and both adjust steps drive alu_b=8'h00.
- Start a=8'h12, b=8'h34. Pulse start again in cycles 2 and 5 with different operands → both ignored; one done with result=8'h46. A start at edge 6 is accepted.
- Assert rst in cycle 3 → busy, alu_own and done drop immediately, result=8'h00, and no done pulse appears after release.
- Check the alu_own/alu_op protocol: alu_own is high in exactly 4 consecutive cycles per operation and alu_op=ALU_OP_ADD throughout; alu_own is never high in IDLE or DONE.
